// File: rtl/ycbcr2rgb_pkg.sv
// Shared constants for the YCbCr->RGB converter: Q8 coefficients, chroma
// offset, pipeline depth and the frame-tracker state encoding.
package ycbcr2rgb_pkg;

  localparam int COEF_R_CR     = 359;
  localparam int COEF_G_CB     = 88;
  localparam int COEF_G_CR     = 183;
  localparam int COEF_B_CB     = 454;
  localparam int CHROMA_OFFSET = 128;
  localparam int LATENCY       = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/ycbcr2rgb_if.sv
// Three-channel pixel port (dctPort_t beats) plus frame status, with a
// master side (pixel source) and a slave side (converter).
interface ycbcr2rgb_if #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 20
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  sop;
    logic                  eop;
  } dctPort_t;

  dctPort_t             in  [3];
  dctPort_t             out [3];
  logic                 frame_err;
  logic                 frame_done;
  logic [CNT_WIDTH-1:0] frame_len;

  modport master (output in, input out, frame_err, frame_done, frame_len);
  modport slave  (input in, output out, frame_err, frame_done, frame_len);

endinterface

// File: rtl/ycbcr2rgb_frame_tracker.sv
// sop/eop framing checker: counts accepted beats per frame, pulses frame_err
// on violations and frame_done with the closed frame's length.
module frame_tracker
  import ycbcr2rgb_pkg::*;
#(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 beat,
  input  logic                 sop,
  input  logic                 eop,
  input  logic                 align_err,
  output logic                 frame_err,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_len
);

  frame_state_t         state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [CNT_WIDTH-1:0] len_reg, len_next;
  logic                 err_reg, err_next;
  logic                 done_reg, done_next;

  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    err_next   = align_err;
    done_next  = 1'b0;
    if (beat) begin
      // A sop always (re)opens a frame; in ACTIVE it also flags the cut-short frame.
      if (sop) begin
        err_next = (state_reg == ACTIVE);
        if (eop) begin
          state_next = IDLE;
          len_next   = CNT_WIDTH'(1);
          done_next  = 1'b1;
        end else begin
          state_next = ACTIVE;
          cnt_next   = CNT_WIDTH'(1);
        end
      end else if (state_reg == IDLE) begin
        err_next = 1'b1;
      end else if (eop) begin
        state_next = IDLE;
        len_next   = cnt_inc;
        done_next  = 1'b1;
      end else begin
        cnt_next = cnt_inc;
      end
    end
  end

  assign frame_err  = err_reg;
  assign frame_done = done_reg;
  assign frame_len  = len_reg;

endmodule

// File: rtl/ycbcr2rgb.sv
// Four-stage fixed-point YCbCr->RGB converter with clamped outputs and a
// matched valid/sop/eop delay line; framing is checked by frame_tracker.
module ycbcr2rgb
  import ycbcr2rgb_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int FRAC       = 8,
  parameter int PIX_MAX    = 255,
  parameter int CNT_WIDTH  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  ycbcr2rgb_if.slave  bus
);

  localparam int XW    = DATA_WIDTH + 1;
  localparam int PW    = XW + 10;
  localparam int SW    = PW + FRAC + 2;
  localparam int ROUND = 1 << (FRAC - 1);

  logic [2:0]            vld_vec, sop_vec, eop_vec;
  logic                  accept, align_err, beat_sop, beat_eop;
  logic [DATA_WIDTH-1:0] y_in, cr_in, cb_in;

  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    assign vld_vec[gi] = bus.in[gi].valid;
    assign sop_vec[gi] = bus.in[gi].sop;
    assign eop_vec[gi] = bus.in[gi].eop;
  end

  assign y_in      = bus.in[0].data;
  assign cr_in     = bus.in[1].data;
  assign cb_in     = bus.in[2].data;
  assign accept    = &vld_vec;
  assign align_err = (|vld_vec) & ~accept;
  assign beat_sop  = accept & (|sop_vec);
  assign beat_eop  = accept & (|eop_vec);

  logic signed [XW-1:0] y1_reg, cb1_reg, cr1_reg, y2_reg;
  logic signed [PW-1:0] p_r_cr_reg, p_g_cb_reg, p_g_cr_reg, p_b_cb_reg;
  logic signed [SW-1:0] sum_reg [3];
  logic signed [SW-1:0] y_sh;

  assign y_sh = SW'(y2_reg) <<< FRAC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_reg     <= '0;
      cb1_reg    <= '0;
      cr1_reg    <= '0;
      y2_reg     <= '0;
      p_r_cr_reg <= '0;
      p_g_cb_reg <= '0;
      p_g_cr_reg <= '0;
      p_b_cb_reg <= '0;
      for (int i = 0; i < 3; i++) sum_reg[i] <= '0;
    end else begin
      y1_reg     <= signed'({1'b0, y_in});
      cb1_reg    <= signed'({1'b0, cb_in}) - XW'(CHROMA_OFFSET);
      cr1_reg    <= signed'({1'b0, cr_in}) - XW'(CHROMA_OFFSET);
      y2_reg     <= y1_reg;
      p_r_cr_reg <= PW'(cr1_reg) * PW'(COEF_R_CR);
      p_g_cb_reg <= PW'(cb1_reg) * PW'(COEF_G_CB);
      p_g_cr_reg <= PW'(cr1_reg) * PW'(COEF_G_CR);
      p_b_cb_reg <= PW'(cb1_reg) * PW'(COEF_B_CB);
      // Index matches the output channel: 2=R, 1=G, 0=B.
      sum_reg[2] <= y_sh + SW'(p_r_cr_reg);
      sum_reg[1] <= y_sh - SW'(p_g_cb_reg) - SW'(p_g_cr_reg);
      sum_reg[0] <= y_sh + SW'(p_b_cb_reg);
    end
  end

  logic [DATA_WIDTH-1:0] pix_reg [3];
  logic [2:0]            ctl_reg [LATENCY];

  for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
    logic signed [SW-1:0] rnd_w;
    assign rnd_w = (sum_reg[gi] + SW'(ROUND)) >>> FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     pix_reg[gi] <= '0;
      else if (rnd_w < 0)             pix_reg[gi] <= '0;
      else if (rnd_w > SW'(PIX_MAX))  pix_reg[gi] <= DATA_WIDTH'(PIX_MAX);
      else                            pix_reg[gi] <= DATA_WIDTH'(rnd_w);
    end

    assign bus.out[gi] = {pix_reg[gi], ctl_reg[LATENCY-1]};
  end

  // {valid, sop, eop} travels alongside the data, one register per stage.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_ctl
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ctl_reg[gi] <= '0;
      else if (gi == 0) ctl_reg[gi] <= {accept, beat_sop, beat_eop};
      else              ctl_reg[gi] <= ctl_reg[(gi == 0) ? 0 : gi - 1];
    end
  end

  logic                 trk_err, trk_done;
  logic [CNT_WIDTH-1:0] trk_len;

  frame_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_frame_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat       (accept),
    .sop        (beat_sop),
    .eop        (beat_eop),
    .align_err  (align_err),
    .frame_err  (trk_err),
    .frame_done (trk_done),
    .frame_len  (trk_len)
  );

  assign bus.frame_err  = trk_err;
  assign bus.frame_done = trk_done;
  assign bus.frame_len  = trk_len;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Scoreboard bench for ycbcr2rgb: directed beats push expected pixels and
// frame events; a negedge monitor pops and compares them cycle-exactly.
module tb_ycbcr2rgb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ycbcr2rgb_if #(.DATA_WIDTH(10), .CNT_WIDTH(20)) bus ();

  ycbcr2rgb #(
    .DATA_WIDTH (10),
    .FRAC       (8),
    .PIX_MAX    (255),
    .CNT_WIDTH  (20)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int r;
    int g;
    int b;
    bit sop;
    bit eop;
  } pix_t;

  typedef struct {
    int cyc;
    int len;
  } done_t;

  pix_t  pix_q  [$];
  done_t done_q [$];
  int    err_q  [$];
  int    checks   = 0;
  int    errors   = 0;
  int    cyc      = 0;
  int    last_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  // sop on channel 0 and eop on channel 2 only, so framing relies on the OR.
  task automatic put(input int y, input int cb, input int cr, input bit [2:0] vmask,
                     input bit sop, input bit eop);
    bus.in[0].data  = 10'(y);
    bus.in[1].data  = 10'(cr);
    bus.in[2].data  = 10'(cb);
    bus.in[0].valid = vmask[0];
    bus.in[1].valid = vmask[1];
    bus.in[2].valid = vmask[2];
    bus.in[0].sop   = sop;
    bus.in[1].sop   = 1'b0;
    bus.in[2].sop   = 1'b0;
    bus.in[0].eop   = 1'b0;
    bus.in[1].eop   = 1'b0;
    bus.in[2].eop   = eop;
  endtask

  task automatic beat(input int y, input int cb, input int cr, input bit sop, input bit eop,
                      input int r, input int g, input int b);
    @(negedge clk);
    put(y, cb, cr, 3'b111, sop, eop);
    pix_q.push_back('{cyc + 4, r, g, b, sop, eop});
  endtask

  task automatic gray(input int y, input bit sop, input bit eop);
    beat(y, 128, 128, sop, eop, y, y, y);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      put(0, 0, 0, 3'b000, 1'b0, 1'b0);
    end
  endtask

  task automatic exp_done(input int len);
    done_q.push_back('{cyc + 1, len});
  endtask

  task automatic exp_err();
    err_q.push_back(cyc + 1);
  endtask

  pix_t  mon_p;
  done_t mon_d;
  int    mon_c;

  always @(negedge clk) begin
    if (bus.out[0].valid || bus.out[1].valid || bus.out[2].valid) begin
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: cyc=%0d got R=%0d G=%0d B=%0d, want no output",
                 cyc, bus.out[2].data, bus.out[1].data, bus.out[0].data);
      end else begin
        mon_p = pix_q.pop_front();
        if (cyc != mon_p.cyc || int'(bus.out[2].data) != mon_p.r ||
            int'(bus.out[1].data) != mon_p.g || int'(bus.out[0].data) != mon_p.b ||
            !(bus.out[0].valid && bus.out[1].valid && bus.out[2].valid) ||
            bus.out[0].sop != mon_p.sop || bus.out[1].sop != mon_p.sop || bus.out[2].sop != mon_p.sop ||
            bus.out[0].eop != mon_p.eop || bus.out[1].eop != mon_p.eop || bus.out[2].eop != mon_p.eop) begin
          errors++;
          $display("FAIL out_beat: got cyc=%0d R=%0d G=%0d B=%0d v=%b%b%b sop=%b eop=%b, want cyc=%0d R=%0d G=%0d B=%0d v=111 sop=%b eop=%b",
                   cyc, bus.out[2].data, bus.out[1].data, bus.out[0].data,
                   bus.out[2].valid, bus.out[1].valid, bus.out[0].valid,
                   bus.out[0].sop, bus.out[0].eop,
                   mon_p.cyc, mon_p.r, mon_p.g, mon_p.b, mon_p.sop, mon_p.eop);
        end else begin
          $display("beat cyc=%0d R=%0d G=%0d B=%0d sop=%b eop=%b ok",
                   cyc, mon_p.r, mon_p.g, mon_p.b, mon_p.sop, mon_p.eop);
        end
      end
    end
    if (bus.frame_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: cyc=%0d len=%0d, want no frame_done", cyc, bus.frame_len);
      end else begin
        mon_d = done_q.pop_front();
        last_len = mon_d.len;
        if (cyc != mon_d.cyc || int'(bus.frame_len) != mon_d.len) begin
          errors++;
          $display("FAIL frame_done: got cyc=%0d len=%0d, want cyc=%0d len=%0d",
                   cyc, bus.frame_len, mon_d.cyc, mon_d.len);
        end else begin
          $display("frame_done cyc=%0d len=%0d ok", cyc, mon_d.len);
        end
      end
    end
    if (bus.frame_err) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL err_unexpected: cyc=%0d, want no frame_err", cyc);
      end else begin
        mon_c = err_q.pop_front();
        if (cyc != mon_c || int'(bus.frame_len) != last_len) begin
          errors++;
          $display("FAIL frame_err: got cyc=%0d len=%0d, want cyc=%0d len=%0d",
                   cyc, bus.frame_len, mon_c, last_len);
        end else begin
          $display("frame_err cyc=%0d len=%0d ok", cyc, last_len);
        end
      end
    end
  end

  initial begin
    put(0, 0, 0, 3'b000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_out_valid", int'(bus.out[0].valid), 0);
    chk("reset_out_data_r", int'(bus.out[2].data), 0);
    chk("reset_frame_len", int'(bus.frame_len), 0);
    chk("reset_err_done", int'({bus.frame_err, bus.frame_done}), 0);
    rst_n = 1'b1;
    idle(2);

    // Single-beat frames with hand-computed colours.
    beat(128, 128, 128, 1, 1, 128, 128, 128); exp_done(1);
    beat(255, 128, 255, 1, 1, 255, 164, 255); exp_done(1);
    beat(0,   0,   0,   1, 1, 0,   136, 0);   exp_done(1);
    beat(100, 200, 50,  1, 1, 0,   131, 228); exp_done(1);
    idle(3);

    // 16-beat frame with idle gaps before beats 5 and 10.
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 10) idle(1);
      gray(10 * i + 5, i == 0, i == 15);
      if (i == 15) exp_done(16);
    end
    idle(3);

    // Beat without sop while idle still passes through.
    gray(50, 0, 0); exp_err();
    idle(2);

    // Second sop mid-frame restarts the count.
    gray(60, 1, 0);
    gray(61, 0, 0);
    gray(62, 1, 0); exp_err();
    gray(63, 0, 0);
    gray(64, 0, 1); exp_done(3);
    idle(2);

    // Channel 1 not valid: beat rejected, error only.
    @(negedge clk);
    put(70, 128, 128, 3'b101, 1'b1, 1'b1); exp_err();
    idle(6);

    // Reset during beat 5 of a frame.
    for (int i = 0; i < 5; i++) gray(20 + i, i == 0, 1'b0);
    @(negedge clk);
    put(25, 128, 128, 3'b111, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    pix_q.delete();
    last_len = 0;
    #1;
    chk("midreset_out_valid", int'(bus.out[0].valid | bus.out[1].valid | bus.out[2].valid), 0);
    chk("midreset_frame_len", int'(bus.frame_len), 0);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    gray(30, 1, 0);
    gray(31, 0, 0);
    gray(32, 0, 1); exp_done(3);
    idle(10);

    chk("pix_q_left", pix_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("err_q_left", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ycbcr2rgb.md
Name: ycbcr2rgb

Overview:
- Inverse colour-space converter: accepts a 3-channel YCbCr stream as dctPort_t beats and produces clamped RGB beats on the same port type.
- Sits on the decoder side, after the inverse-DCT / dequantisation path, and feeds the pixel output stage.
- Fully pipelined, one beat per clock.
- Carries a frame-tracking FSM that checks sop/eop framing, flags violations and reports the beat count of each completed frame.

Parameters:
- DATA_WIDTH, 10: width of each channel data field; signed arithmetic is done internally.
- FRAC, 8: fractional bits of the fixed-point coefficients.
- PIX_MAX, 255: upper clamp value of the RGB outputs.
- CNT_WIDTH, 20: width of the per-frame beat counter.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in, input, dctPort_t[3]: in[0]=Y, in[1]=Cr, in[2]=Cb.
- out, output, dctPort_t[3]: out[2]=R, out[1]=G, out[0]=B.
- frame_err, output, 1: one-cycle pulse on a framing or channel-alignment violation.
- frame_len, output, CNT_WIDTH: beat count of the last completed frame.
- frame_done, output, 1: one-cycle pulse when frame_len updates.

Behaviour:
- Reset: every pipeline register, out[*].data/valid/sop/eop, frame_err, frame_done and frame_len clear to 0. FSM goes to IDLE. Asserting rst_n low mid-frame discards all in-flight beats; no partial output appears after release.
- Input qualification: a beat is accepted when &in[*].valid. sop = |in[*].sop, eop = |in[*].eop, taken from accepted beats only.
- Arithmetic, Q8 coefficients, fixed latency 4 cycles:
  - S1: y = Y; cb = Cb-128; cr = Cr-128 (signed, DATA_WIDTH+1 bits).
  - S2: products 359*cr, 88*cb, 183*cr, 454*cb, registered.
  - S3: R' = (y<<8)+359cr; G' = (y<<8)-88cb-183cr; B' = (y<<8)+454cb. Internal width is sufficient that no intermediate overflows.
  - S4: add 2^(FRAC-1), arithmetic shift right by FRAC, clamp to [0, PIX_MAX], zero-extend to DATA_WIDTH.
- Control delay: valid, sop and eop are delayed exactly 4 cycles, aligned with data, and replicated to all three out channels.
  - out[*].data is don't-care when valid=0; the bench checks data only when valid=1.
- Frame FSM (runs on accepted input beats, not the delayed ones):
  - IDLE + sop & !eop → ACTIVE; cnt=1.
  - IDLE + sop & eop → stay IDLE; frame_len=1; frame_done pulse.
  - IDLE + beat without sop → frame_err pulse; stay IDLE; beat still passes through the datapath.
  - ACTIVE + beat, no sop/eop → cnt+1.
  - ACTIVE + eop → IDLE; frame_len=cnt+1; frame_done pulse.
  - ACTIVE + sop (with or without eop) → frame_err pulse, then restart: cnt=1 (or close as a 1-beat frame if eop is also set).
  - cnt saturates at all-ones and never wraps.
- Channel alignment: |in[*].valid & ~&in[*].valid (some but not all channels valid) → frame_err pulse; the beat is not accepted.
- Simultaneous events: an alignment error and a framing error in the same cycle produce a single frame_err pulse.
- frame_err and frame_done are registered, one cycle after the input beat, independent of datapath latency.

Decomposition:
- Shared package:
  - coefficient constants (COEF_R_CR=359, COEF_G_CB=88, COEF_G_CR=183, COEF_B_CB=454);
  - CHROMA_OFFSET=128;
  - LATENCY=4;
  - FSM state enum (IDLE, ACTIVE).
- dctPort_t stays in the existing interface file.
- One sub-module, frame_tracker, holds the FSM, counter and error logic. The datapath and the control delay line live in the top module.

Test Plan:
- Y=128, Cb=128, Cr=128, single beat with sop&eop → 4 cycles later R=G=B=128, valid/sop/eop=1; frame_done pulse with frame_len=1.
- Y=255, Cb=128, Cr=255 → R=255 (clamped), G=164, B=255.
- Y=0, Cb=0, Cr=0 → R=0 (clamped), G=136, B=0.
- 16-beat frame (sop on beat 0, eop on beat 15) with 2 idle gaps → outputs keep the same gaps shifted by 4 cycles; frame_len=16; no frame_err.
- Framing faults → frame_err pulses one cycle after each fault, with frame_len unchanged:
  - beat without sop while IDLE;
  - second sop mid-frame;
  - in[1].valid=0 while the other channels are valid.
- rst_n pulled low during beat 5 of a frame:
  - out valid drops immediately and stays 0 after release until new input arrives;
  - a following 3-beat frame gives frame_len=3.
